// File: rtl/wb_regfile_arbiter.sv
// wb_regfile_arbiter
// Shares the register-file write port between the in-order writeback stage
// and buffered multiply/divide (MDU) results. MDU results wait in a small
// FIFO and drain in cycles where writeback does not write. A starvation
// counter forces a one-cycle pipeline stall so the FIFO head always drains.
// pend_hit lets decode detect hazards against buffered results.
//
// Optional feature: define WB_ARB_BYPASS_EN to write an MDU result straight
// to the register file when the FIFO is empty and the port is otherwise idle.
module wb_regfile_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        mdu_valid,
    input  logic [4:0]  mdu_rd,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_rd,
    output logic [31:0] rf_wdata,
    output logic        pipe_stall,
    input  logic [4:0]  chk_rs1,
    input  logic [4:0]  chk_rs2,
    input  logic [4:0]  chk_rd,
    output logic        pend_hit
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1) + 1;
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);

    // FIFO storage: every entry is visible at once for the pending lookup
    logic [4:0]    fifo_rd_reg   [DEPTH];
    logic [31:0]   fifo_data_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [PW:0]   count_reg;
    logic [CW-1:0] starve_cnt_reg;
    logic          pipe_stall_reg;

    logic [CW-1:0] starve_cnt_next;
    logic          pipe_stall_next;

    logic          empty;
    logic          full;
    logic          pipe_wr;
    logic          grant_pipe;
    logic          grant_fifo;
    logic          push;
    logic          pop;
    logic [DEPTH-1:0] entry_hit;
`ifdef WB_ARB_BYPASS_EN
    logic          grant_byp;
`endif

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_CNT);
    // A write to x0 is no write at all; it leaves the port free for the FIFO
    assign pipe_wr = pipe_valid && (pipe_rd != 5'd0);

    // Ready comes from registered occupancy only, so a pop never lets a push
    // through in the same cycle while full
    assign mdu_ready  = !rst && !full;
    assign pipe_stall = pipe_stall_reg;
    assign pop        = grant_fifo;

`ifdef WB_ARB_BYPASS_EN
    assign push = mdu_valid && !full && (mdu_rd != 5'd0) && !grant_byp;
`else
    assign push = mdu_valid && !full && (mdu_rd != 5'd0);
`endif

    // Grant selection: a forced stall drains the head, otherwise writeback
    // wins, otherwise the FIFO head (or, with bypass, the live MDU result)
    always_comb begin
        grant_pipe = 1'b0;
        grant_fifo = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        grant_byp  = 1'b0;
`endif
        if (pipe_stall_reg) begin
            grant_fifo = !empty;
        end else if (pipe_wr) begin
            grant_pipe = 1'b1;
        end else if (!empty) begin
            grant_fifo = 1'b1;
        end
`ifdef WB_ARB_BYPASS_EN
        else if (mdu_valid && (mdu_rd != 5'd0)) begin
            grant_byp = 1'b1;
        end
`endif
    end

    // Register-file write mux; nothing is written while reset is held
    always_comb begin
        rf_we    = 1'b0;
        rf_rd    = 5'd0;
        rf_wdata = 32'd0;
        if (grant_pipe) begin
            rf_we    = !rst;
            rf_rd    = pipe_rd;
            rf_wdata = pipe_data;
        end else if (grant_fifo) begin
            rf_we    = !rst;
            rf_rd    = fifo_rd_reg[rd_ptr_reg];
            rf_wdata = fifo_data_reg[rd_ptr_reg];
        end
`ifdef WB_ARB_BYPASS_EN
        else if (grant_byp) begin
            rf_we    = !rst;
            rf_rd    = mdu_rd;
            rf_wdata = mdu_data;
        end
`endif
    end

    // Starvation tracking: count pipeline wins over a waiting head and
    // request a one-cycle stall when the limit is reached
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        pipe_stall_next = 1'b0;
        if (pop || empty) begin
            starve_cnt_next = '0;
        end else if (grant_pipe) begin
            starve_cnt_next = starve_cnt_reg + CW'(1);
            if (starve_cnt_next >= LIMIT_CNT) begin
                pipe_stall_next = 1'b1;
            end
        end
    end

    // Pointer, occupancy, counter and stall state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg     <= '0;
            wr_ptr_reg     <= '0;
            count_reg      <= '0;
            starve_cnt_reg <= '0;
            pipe_stall_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + (PW + 1)'(1);
                2'b01:   count_reg <= count_reg - (PW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
            starve_cnt_reg <= starve_cnt_next;
            pipe_stall_reg <= pipe_stall_next;
        end
    end

    // Entry payload write; contents need no reset since occupancy gates use
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd_reg[wr_ptr_reg]   <= mdu_rd;
            fifo_data_reg[wr_ptr_reg] <= mdu_data;
        end
    end

    // Per-entry hazard match against the decode lookup addresses
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        localparam logic [PW-1:0] IDX = PW'(gi);
        logic [PW-1:0] offset;
        logic          entry_valid;
        assign offset      = IDX - rd_ptr_reg;
        assign entry_valid = ({1'b0, offset} < count_reg);
        assign entry_hit[gi] = entry_valid && (
            ((fifo_rd_reg[gi] == chk_rs1) && (chk_rs1 != 5'd0)) ||
            ((fifo_rd_reg[gi] == chk_rs2) && (chk_rs2 != 5'd0)) ||
            ((fifo_rd_reg[gi] == chk_rd)  && (chk_rd  != 5'd0)));
    end

    assign pend_hit = |entry_hit;

endmodule

// File: tb/tb_wb_regfile_arbiter.sv
// Testbench for wb_regfile_arbiter: directed vectors; expected register-file
// writes go into a queue that a negedge monitor pops whenever rf_we is high.
module tb_wb_regfile_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mdu_valid;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        pend_hit;

`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;

    wb_regfile_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .mdu_valid  (mdu_valid),
        .mdu_rd     (mdu_rd),
        .mdu_data   (mdu_data),
        .mdu_ready  (mdu_ready),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_wdata   (rf_wdata),
        .pipe_stall (pipe_stall),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .pend_hit   (pend_hit)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
            $display("check %-16s got %08h expected %08h ok", name, act, exp);
        end else begin
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic set_pipe(input logic v, input logic [4:0] rd, input logic [31:0] d);
        pipe_valid = v;
        pipe_rd    = rd;
        pipe_data  = d;
    endtask

    task automatic set_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        mdu_valid = v;
        mdu_rd    = rd;
        mdu_data  = d;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back('{rd: rd, data: d});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every register-file write must match the next expected write
    always @(negedge clk) begin
        if (!rst && rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_wr: got rd=%0d data=%08h expected no write", rf_rd, rf_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_rd", 32'(rf_rd), 32'(e.rd));
                check("wr_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        set_pipe(1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
        chk_rs1 = 5'd0;
        chk_rs2 = 5'd0;
        chk_rd  = 5'd0;

        // Reset state
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(mdu_ready), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_stall", 32'(pipe_stall), 32'd0);
        check("rst_hit", 32'(pend_hit), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(mdu_ready), 32'd1);
        next_cycle();

        // Idle drain: push {5, 0x12345678}, written the following cycle
        set_mdu(1'b1, 5'd5, 32'h1234_5678);
        if (BYP) expect_wr(5'd5, 32'h1234_5678);
        @(negedge clk);
        check("idle_push_we", 32'(rf_we), 32'(BYP));
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        if (!BYP) expect_wr(5'd5, 32'h1234_5678);
        @(negedge clk);
        check("idle_drain_we", 32'(rf_we), 32'(!BYP));
        next_cycle();

        // Priority: buffered {3,0xA} yields to pipe {7,0xB}, drains next
        set_pipe(1'b1, 5'd6, 32'hC);
        set_mdu(1'b1, 5'd3, 32'hA);
        expect_wr(5'd6, 32'hC);
        next_cycle();
        set_pipe(1'b1, 5'd7, 32'hB);
        set_mdu(1'b0, 5'd0, 32'd0);
        expect_wr(5'd7, 32'hB);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'd0);
        expect_wr(5'd3, 32'hA);
        @(negedge clk);
        check("prio_fifo_we", 32'(rf_we), 32'd1);
        next_cycle();
        @(negedge clk);
        check("prio_idle_we", 32'(rf_we), 32'd0);
        next_cycle();

        // Starvation: head {9} waits through 4 pipeline grants, then a stall
        set_pipe(1'b1, 5'd10, 32'h100);
        set_mdu(1'b1, 5'd9, 32'h99);
        expect_wr(5'd10, 32'h100);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            set_pipe(1'b1, 5'(10 + i), 32'h100 + 32'(i));
            expect_wr(5'(10 + i), 32'h100 + 32'(i));
            @(negedge clk);
            check("starve_no_stall", 32'(pipe_stall), 32'd0);
            next_cycle();
        end
        set_pipe(1'b1, 5'd15, 32'h105);
        expect_wr(5'd9, 32'h99);
        @(negedge clk);
        check("starve_stall", 32'(pipe_stall), 32'd1);
        check("starve_stall_rd", 32'(rf_rd), 32'd9);
        next_cycle();
        expect_wr(5'd15, 32'h105);
        @(negedge clk);
        check("starve_resume", 32'(pipe_stall), 32'd0);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("starve_idle_we", 32'(rf_we), 32'd0);
        next_cycle();

        // Full / backpressure: two pushes fill the FIFO, third is held
        set_pipe(1'b1, 5'd1, 32'h1);
        set_mdu(1'b1, 5'd20, 32'h20);
        expect_wr(5'd1, 32'h1);
        next_cycle();
        set_pipe(1'b1, 5'd2, 32'h2);
        set_mdu(1'b1, 5'd21, 32'h21);
        expect_wr(5'd2, 32'h2);
        @(negedge clk);
        check("full_ready_1", 32'(mdu_ready), 32'd1);
        next_cycle();
        set_mdu(1'b1, 5'd22, 32'h22);
        for (int i = 3; i <= 5; i++) begin
            set_pipe(1'b1, 5'(i), 32'(i));
            expect_wr(5'(i), 32'(i));
            @(negedge clk);
            check("full_not_ready", 32'(mdu_ready), 32'd0);
            next_cycle();
        end
        set_pipe(1'b1, 5'd6, 32'h6);
        expect_wr(5'd20, 32'h20);
        @(negedge clk);
        check("full_pop_stall", 32'(pipe_stall), 32'd1);
        check("full_pop_ready", 32'(mdu_ready), 32'd0);
        next_cycle();
        expect_wr(5'd6, 32'h6);
        @(negedge clk);
        check("full_after_pop", 32'(mdu_ready), 32'd1);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'd0);
        set_mdu(1'b0, 5'd0, 32'd0);
        expect_wr(5'd21, 32'h21);
        next_cycle();
        expect_wr(5'd22, 32'h22);
        next_cycle();
        @(negedge clk);
        check("full_drained_we", 32'(rf_we), 32'd0);
        next_cycle();

        // x0: MDU result to x0 is handshaken but discarded
        set_mdu(1'b1, 5'd0, 32'hDEAD);
        @(negedge clk);
        check("x0_ready", 32'(mdu_ready), 32'd1);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("x0_no_write", 32'(rf_we), 32'd0);
        check("x0_no_hit", 32'(pend_hit), 32'd0);
        next_cycle();
        // Pipe write to x0 frees the port for the FIFO head
        set_pipe(1'b1, 5'd4, 32'h4);
        set_mdu(1'b1, 5'd8, 32'h88);
        expect_wr(5'd4, 32'h4);
        next_cycle();
        set_pipe(1'b1, 5'd0, 32'hFFFF);
        set_mdu(1'b0, 5'd0, 32'd0);
        expect_wr(5'd8, 32'h88);
        @(negedge clk);
        check("x0_pipe_fifo_rd", 32'(rf_rd), 32'd8);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'd0);
        @(negedge clk);
        check("x0_idle_we", 32'(rf_we), 32'd0);
        next_cycle();

        // Lookup and asynchronous reset mid-operation
        set_pipe(1'b1, 5'd1, 32'h11);
        set_mdu(1'b1, 5'd12, 32'hC);
        expect_wr(5'd1, 32'h11);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd2, 32'h12);
        chk_rs2 = 5'd12;
        expect_wr(5'd2, 32'h12);
        @(negedge clk);
        check("lookup_rs2_hit", 32'(pend_hit), 32'd1);
        next_cycle();
        set_pipe(1'b1, 5'd3, 32'h13);
        chk_rs2 = 5'd0;
        expect_wr(5'd3, 32'h13);
        @(negedge clk);
        check("lookup_x0_nohit", 32'(pend_hit), 32'd0);
        next_cycle();
        set_pipe(1'b1, 5'd4, 32'h14);
        set_mdu(1'b1, 5'd13, 32'hD);
        chk_rs1 = 5'd14;
        expect_wr(5'd4, 32'h14);
        @(negedge clk);
        check("lookup_miss", 32'(pend_hit), 32'd0);
        next_cycle();
        set_mdu(1'b0, 5'd0, 32'd0);
        set_pipe(1'b1, 5'd5, 32'h15);
        chk_rs1 = 5'd0;
        expect_wr(5'd5, 32'h15);
        next_cycle();
        // Stall cycle: head {12} drains, {13} remains buffered
        expect_wr(5'd12, 32'hC);
        chk_rd = 5'd13;
        @(negedge clk);
        check("rst_pre_stall", 32'(pipe_stall), 32'd1);
        check("rst_pre_hit", 32'(pend_hit), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_ready", 32'(mdu_ready), 32'd0);
        check("async_hit", 32'(pend_hit), 32'd0);
        check("async_stall", 32'(pipe_stall), 32'd0);
        check("async_we", 32'(rf_we), 32'd0);
        next_cycle();
        @(negedge clk);
        check("rst_held_we", 32'(rf_we), 32'd0);
        next_cycle();
        set_pipe(1'b0, 5'd0, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(mdu_ready), 32'd1);
        check("post_rst_lost", 32'(rf_we), 32'd0);
        check("post_rst_hit", 32'(pend_hit), 32'd0);
        next_cycle();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
